// File: rtl/gerador_sequencia_pkg.sv
// Shared lamp-bus definitions for the lamp-code generator and detector.
// Optional repeat mode of the generator is enabled with GERADOR_REPEAT_EN.
package lampadas_pkg;
   localparam int NBITS = 2;

   localparam logic [NBITS-1:0] LAMP_OFF  = 2'd0;
   localparam logic [NBITS-1:0] LAMP_UM   = 2'd1;
   localparam logic [NBITS-1:0] LAMP_DOIS = 2'd2;
   localparam logic [NBITS-1:0] LAMP_TRES = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } estado_t;

   // Code 0 sits in the low bits, so this emits 1, 2, 3 in that order.
   localparam logic [3*NBITS-1:0] SEQ_123 = {LAMP_TRES, LAMP_DOIS, LAMP_UM};
endpackage

// File: rtl/gerador_sequencia_if.sv
// Control/lamp-bus bundle between user logic (master) and the generator (slave).
// Carries the extra `loop` request when GERADOR_REPEAT_EN is defined.
interface gerador_sequencia_if #(
   parameter int NBITS  = 2,
   parameter int MAXLEN = 4
);
   localparam int LW = $clog2(MAXLEN + 1);

   logic                    start;
   logic [MAXLEN*NBITS-1:0] seq_in;
   logic [LW-1:0]           len;
`ifdef GERADOR_REPEAT_EN
   logic                    loop;
`endif
   logic [NBITS-1:0]        lampadas;
   logic                    busy;
   logic                    done;

   modport master (
`ifdef GERADOR_REPEAT_EN
      output loop,
`endif
      output start, seq_in, len,
      input  lampadas, busy, done
   );

   modport slave (
`ifdef GERADOR_REPEAT_EN
      input  loop,
`endif
      input  start, seq_in, len,
      output lampadas, busy, done
   );
endinterface

// File: rtl/gerador_sequencia_contador_hold.sv
// Loadable down-counter; tc flags the last cycle of a hold or gap interval.
module contador_hold #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);
   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign tc = (count_reg == '0);
endmodule

// File: rtl/gerador_sequencia.sv
// Lamp-code sequence generator: emits latched codes, HOLD cycles each, then GAP idle cycles and a done pulse.
// Define GERADOR_REPEAT_EN to add the `loop` input that restarts the pattern instead of finishing.
module gerador_sequencia #(
   parameter int NBITS  = 2,
   parameter int MAXLEN = 4,
   parameter int HOLD   = 1,
   parameter int GAP    = 2
) (
   input  logic               clk,
   input  logic               reset,
   gerador_sequencia_if.slave bus
);
   import lampadas_pkg::*;

   localparam int LW   = $clog2(MAXLEN + 1);
   localparam int TMAX = (HOLD > GAP) ? HOLD : ((GAP > 0) ? GAP : 1);
   localparam int CW   = $clog2(TMAX + 1);

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LOAD  = (GAP > 0) ? CW'(GAP - 1) : '0;
   localparam logic [LW-1:0] MAXLEN_L  = LW'(MAXLEN);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_EMIT = ST_EMIT;
   localparam logic [1:0] S_GAP  = ST_GAP;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]              state_reg, state_next;
   logic [MAXLEN*NBITS-1:0] seq_reg, seq_next;
   logic [LW-1:0]           len_reg, len_next;
   logic [LW-1:0]           idx_reg, idx_next;
   logic [NBITS-1:0]        lampadas_reg, lampadas_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;

   logic [LW-1:0]           len_clamped;
   logic                    cnt_load, cnt_en, cnt_tc;
   logic [CW-1:0]           cnt_load_val;
   logic                    to_gap, to_end;

   assign len_clamped = (bus.len > MAXLEN_L) ? MAXLEN_L : bus.len;

   contador_hold #(.W(CW)) u_contador (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .tc       (cnt_tc)
   );

   // Outputs are computed one cycle ahead so lampadas/busy/done come straight from flops.
   always_comb begin
      state_next    = state_reg;
      seq_next      = seq_reg;
      len_next      = len_reg;
      idx_next      = idx_reg;
      lampadas_next = '0;
      done_next     = 1'b0;
      cnt_load      = 1'b0;
      cnt_load_val  = HOLD_LOAD;
      cnt_en        = 1'b0;
      to_gap        = 1'b0;
      to_end        = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               seq_next = bus.seq_in;
               len_next = len_clamped;
               idx_next = '0;
               if (len_clamped != '0) begin
                  state_next    = S_EMIT;
                  lampadas_next = bus.seq_in[NBITS-1:0];
                  cnt_load      = 1'b1;
               end else begin
                  to_gap = 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (cnt_tc) begin
               if (idx_reg == len_reg - 1'b1) begin
                  to_gap = 1'b1;
               end else begin
                  idx_next      = idx_reg + 1'b1;
                  lampadas_next = seq_reg[idx_next*NBITS +: NBITS];
                  cnt_load      = 1'b1;
               end
            end else begin
               cnt_en        = 1'b1;
               lampadas_next = lampadas_reg;
            end
         end
         S_GAP: begin
            if (cnt_tc) begin
               to_end = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // A zero-length gap falls straight through to completion.
      if (to_gap) begin
         if (GAP > 0) begin
            state_next   = S_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
         end else begin
            to_end = 1'b1;
         end
      end

      if (to_end) begin
         done_next  = 1'b1;
         state_next = S_DONE;
`ifdef GERADOR_REPEAT_EN
         if (bus.loop && len_next != '0) begin
            state_next    = S_EMIT;
            idx_next      = '0;
            lampadas_next = seq_next[NBITS-1:0];
            cnt_load      = 1'b1;
            cnt_load_val  = HOLD_LOAD;
         end
`endif
      end

      busy_next = (state_next != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         seq_reg      <= '0;
         len_reg      <= '0;
         idx_reg      <= '0;
         lampadas_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         seq_reg      <= seq_next;
         len_reg      <= len_next;
         idx_reg      <= idx_next;
         lampadas_reg <= lampadas_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   assign bus.lampadas = lampadas_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
endmodule

// File: tb/tb_gerador_sequencia.sv
// Self-checking bench: two generators (HOLD=1 and HOLD=3, GAP=2) driven in lockstep,
// per-cycle scoreboard of expected lampadas/busy/done plus table and corner-case sequences.
module tb_gerador_sequencia;
   import lampadas_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gerador_sequencia_if #(.NBITS(2), .MAXLEN(4)) bus1 ();
   gerador_sequencia_if #(.NBITS(2), .MAXLEN(4)) bus3 ();

   gerador_sequencia #(.NBITS(2), .MAXLEN(4), .HOLD(1), .GAP(2)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   gerador_sequencia #(.NBITS(2), .MAXLEN(4), .HOLD(3), .GAP(2)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   typedef struct packed {
      logic [1:0] lamp;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      logic [7:0] sq;
      logic [2:0] ln;
      int         busy1;
      int         busy3;
   } vec_t;

   obs_t q1[$];
   obs_t q3[$];
   bit   cur_done1 = 1'b0;
   bit   cur_done3 = 1'b0;
   int   n_total   = 0;
   int   n_pass    = 0;
   int   cyc       = 0;

   // Expected per-cycle trace from the specified timing: codes, GAP idle cycles, one done cycle.
   function automatic void push_trace(input int which, input int hold,
                                      input logic [7:0] sq, input logic [2:0] ln);
      int   n;
      obs_t e;
      logic [7:0] s;
      s = sq;
      n = (ln > 3'd4) ? 4 : int'(ln);
      for (int j = 0; j < n; j++) begin
         for (int h = 0; h < hold; h++) begin
            e.lamp = s[j*2 +: 2];
            e.busy = 1'b1;
            e.done = 1'b0;
            if (which == 1) q1.push_back(e); else q3.push_back(e);
         end
      end
      for (int g = 0; g < 2; g++) begin
         e = '{lamp: 2'd0, busy: 1'b1, done: 1'b0};
         if (which == 1) q1.push_back(e); else q3.push_back(e);
      end
      e = '{lamp: 2'd0, busy: 1'b1, done: 1'b1};
      if (which == 1) q1.push_back(e); else q3.push_back(e);
   endfunction

   function automatic void check_obs(input string name, input obs_t got, input obs_t want);
      n_total++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s cyc=%0d got lamp=%0d busy=%0d done=%0d want lamp=%0d busy=%0d done=%0d",
                  name, cyc, got.lamp, got.busy, got.done, want.lamp, want.busy, want.done);
      end
   endfunction

   function automatic void check_int(input string name, input int got, input int want);
      n_total++;
      if (got == want) begin
         n_pass++;
         $display("check %s: got %0d want %0d ok", name, got, want);
      end else begin
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endfunction

   // One clock: drive inputs for the coming edge, then compare the following cycle.
   task automatic step(input logic st, input logic rs, input logic [7:0] sq, input logic [2:0] ln);
      obs_t got, want;
      reset       = rs;
      bus1.start  = st;
      bus1.seq_in = sq;
      bus1.len    = ln;
      bus3.start  = st;
      bus3.seq_in = sq;
      bus3.len    = ln;
      if (!rs) begin
         q1.delete();
         q3.delete();
      end else if (st) begin
         if (q1.size() == 0 && !cur_done1) push_trace(1, 1, sq, ln);
         if (q3.size() == 0 && !cur_done3) push_trace(3, 3, sq, ln);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;

      got = {bus1.lampadas, bus1.busy, bus1.done};
      if (q1.size() > 0) want = q1.pop_front(); else want = '0;
      check_obs("dut1_cycle", got, want);
      cur_done1 = want.done;

      got = {bus3.lampadas, bus3.busy, bus3.done};
      if (q3.size() > 0) want = q3.pop_front(); else want = '0;
      check_obs("dut3_cycle", got, want);
      cur_done3 = want.done;
   endtask

   vec_t       tbl[7];
   logic [7:0] s123;
   int         b1, b3, d1, d3, first_done;

   initial begin
      s123 = 8'(SEQ_123);
      tbl[0] = '{sq: s123,  ln: 3'd3, busy1: 6, busy3: 12};
      tbl[1] = '{sq: 8'h09, ln: 3'd2, busy1: 5, busy3: 9};
      tbl[2] = '{sq: 8'h00, ln: 3'd0, busy1: 3, busy3: 3};
      tbl[3] = '{sq: 8'hE4, ln: 3'd4, busy1: 7, busy3: 15};
      tbl[4] = '{sq: 8'h19, ln: 3'd3, busy1: 6, busy3: 12};
      tbl[5] = '{sq: 8'hE5, ln: 3'd4, busy1: 7, busy3: 15};
      tbl[6] = '{sq: 8'hE5, ln: 3'd7, busy1: 7, busy3: 15};

`ifdef GERADOR_REPEAT_EN
      bus1.loop = 1'b0;
      bus3.loop = 1'b0;
`endif

      // Reset for two cycles, then quiet with start low.
      step(1'b0, 1'b0, 8'h00, 3'd0);
      step(1'b0, 1'b0, 8'h00, 3'd0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 3'd0);

      // Table: one start per vector; inputs scrambled after acceptance.
      for (int i = 0; i < 7; i++) begin
         b1 = 0;
         b3 = 0;
         step(1'b1, 1'b1, tbl[i].sq, tbl[i].ln);
         b1 += int'(bus1.busy);
         b3 += int'(bus3.busy);
         for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 8'hFF, 3'd1);
            b1 += int'(bus1.busy);
            b3 += int'(bus3.busy);
         end
         check_int($sformatf("busy_len_dut1_v%0d", i), b1, tbl[i].busy1);
         check_int($sformatf("busy_len_dut3_v%0d", i), b3, tbl[i].busy3);
      end

      // Restart attempts during EMIT and in the DONE cycle, then one cycle later in IDLE.
      d1 = 0;
      d3 = 0;
      first_done = -1;
      for (int c = 0; c < 20; c++) begin
         step((c == 0 || c == 2 || c == 6 || c == 7), 1'b1, s123, 3'd3);
         if (bus1.done && first_done < 0) first_done = c + 1;
         d1 += int'(bus1.done);
         d3 += int'(bus3.done);
      end
      check_int("first_done_cycle_dut1", first_done, 6);
      check_int("done_count_dut1", d1, 2);
      check_int("done_count_dut3", d3, 1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 3'd0);

      // Reset during the second code aborts without done; a fresh start then runs normally.
      step(1'b1, 1'b1, s123, 3'd3);
      step(1'b0, 1'b1, s123, 3'd3);
      check_int("second_code_dut1", int'(bus1.lampadas), 2);
      step(1'b0, 1'b0, s123, 3'd3);
      d1 = 0;
      d3 = 0;
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 1'b1, s123, 3'd3);
         d1 += int'(bus1.done);
         d3 += int'(bus3.done);
      end
      check_int("abort_done_dut1", d1, 0);
      check_int("abort_done_dut3", d3, 0);
      b1 = 0;
      b3 = 0;
      step(1'b1, 1'b1, s123, 3'd3);
      b1 += int'(bus1.busy);
      b3 += int'(bus3.busy);
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b1, 8'h00, 3'd0);
         b1 += int'(bus1.busy);
         b3 += int'(bus3.busy);
      end
      check_int("restart_busy_dut1", b1, 6);
      check_int("restart_busy_dut3", b3, 12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
